mem_port_arbiter: RTL and testbench

//  Shares the single instruction/data memory port between instruction fetch and the data
//  (load/store) path. Arbitrates round-robin and sequences each access over MEM_LATENCY cycles.

---
 rtl/cpu_ctrl_pkg.sv | 15 +
 rtl/rr_pick_2.sv | 22 ++
 rtl/mem_port_arbiter.sv | 104 ++++++++++
 tb/tb_mem_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the CPU control slice: memory-port arbiter states and requester ids.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACCESS,
        ARB_ACK
    } arb_state_t;

    typedef enum logic {
        REQ_INS,
        REQ_DATA
    } req_id_t;

endpackage

// File: rtl/rr_pick_2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the one not granted last.
module rr_pick_2
    import cpu_ctrl_pkg::*;
(
    input  logic    ins_req,
    input  logic    data_req,
    input  req_id_t last_grant,
    output req_id_t winner_c,
    output logic    valid_c
);

    always_comb begin
        winner_c = REQ_INS;
        if (ins_req && data_req) begin
            winner_c = (last_grant == REQ_INS) ? REQ_DATA : REQ_INS;
        end else if (data_req) begin
            winner_c = REQ_DATA;
        end
        valid_c = ins_req | data_req;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between fetch and load/store; round-robin grant,
// MEM_LATENCY-cycle strobe window, then a one-cycle ack to the winner.
module mem_port_arbiter
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ins_req,
    input  logic data_req,
    input  logic data_we,
    output logic sel_ins,
    output logic sel_data,
    output logic mem_rd,
    output logic mem_wr,
    output logic ins_ack,
    output logic data_ack,
    output logic busy
);

    localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 1);

    arb_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    req_id_t          gnt, gnt_nxt;
    req_id_t          last_grant, last_grant_nxt;
    logic             we_q, we_nxt;

    req_id_t pick_winner;
    logic    pick_valid;

    rr_pick_2 u_pick (
        .ins_req    (ins_req),
        .data_req   (data_req),
        .last_grant (last_grant),
        .winner_c   (pick_winner),
        .valid_c    (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            cnt        <= '0;
            gnt        <= REQ_INS;
            last_grant <= REQ_DATA;
            we_q       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            gnt        <= gnt_nxt;
            last_grant <= last_grant_nxt;
            we_q       <= we_nxt;
        end
    end

    // Requests are only looked at in IDLE; gnt and we_q are frozen for the whole window.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        gnt_nxt        = gnt;
        last_grant_nxt = last_grant;
        we_nxt         = we_q;
        case (state)
            ARB_IDLE: begin
                if (pick_valid) begin
                    gnt_nxt        = pick_winner;
                    last_grant_nxt = pick_winner;
                    cnt_nxt        = CNT_W'(MEM_LATENCY - 1);
                    we_nxt         = (pick_winner == REQ_DATA) ? data_we : 1'b0;
                    state_nxt      = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                if (cnt == '0) begin
                    state_nxt = ARB_ACK;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ARB_ACK: begin
                state_nxt = ARB_IDLE;
            end
            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
    end

    logic in_access;
    logic in_window;

    assign in_access = (state == ARB_ACCESS);
    assign in_window = (state == ARB_ACCESS) || (state == ARB_ACK);

    assign sel_ins  = in_window && (gnt == REQ_INS);
    assign sel_data = in_window && (gnt == REQ_DATA);
    assign mem_rd   = in_access && !we_q;
    assign mem_wr   = in_access && we_q;
    assign ins_ack  = (state == ARB_ACK) && (gnt == REQ_INS);
    assign data_ack = (state == ARB_ACK) && (gnt == REQ_DATA);
    assign busy     = in_window;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and random checks for mem_port_arbiter at MEM_LATENCY=2.
module tb_mem_port_arbiter;

    localparam int LAT = 2;

    logic clk;
    logic rst_n;
    logic ins_req;
    logic data_req;
    logic data_we;
    logic sel_ins;
    logic sel_data;
    logic mem_rd;
    logic mem_wr;
    logic ins_ack;
    logic data_ack;
    logic busy;

    int total;
    int passed;

    mem_port_arbiter #(.MEM_LATENCY(LAT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ins_req  (ins_req),
        .data_req (data_req),
        .data_we  (data_we),
        .sel_ins  (sel_ins),
        .sel_data (sel_data),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .ins_ack  (ins_ack),
        .data_ack (data_ack),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {busy, sel_ins, sel_data, mem_rd, mem_wr, ins_ack, data_ack}
    function automatic logic [6:0] outs();
        return {busy, sel_ins, sel_data, mem_rd, mem_wr, ins_ack, data_ack};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ins_req  = 1'b0;
        data_req = 1'b0;
        data_we  = 1'b0;
        rst_n    = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        ins_req  = 1'b1;
        data_req = 1'b1;
        data_we  = 1'b0;
        rst_n    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (outs() !== 7'b0)
                $display("FAIL reset edge %0d: got %b want %b", i, outs(), 7'b0);
            else
                passed++;
        end
        rst_n = 1'b1;
        step();
        total++;
        if (outs() !== 7'b1101000)
            $display("FAIL reset_first_grant: got %b want %b", outs(), 7'b1101000);
        else
            passed++;
    endtask

    task automatic test_ins_only();
        logic [6:0] exp [4];
        exp = '{7'b1101000, 7'b1101000, 7'b1100010, 7'b0000000};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            ins_req = (c < 3);
            step();
            total++;
            if (outs() !== exp[c])
                $display("FAIL ins_only cycle %0d: got %b want %b", c + 1, outs(), exp[c]);
            else
                passed++;
        end
    endtask

    task automatic test_tie();
        logic [6:0] exp [8];
        exp = '{7'b1101000, 7'b1101000, 7'b1100010, 7'b0000000,
                7'b1011000, 7'b1011000, 7'b1010001, 7'b0000000};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            ins_req  = (c < 3);
            data_req = (c < 7);
            step();
            total++;
            if (outs() !== exp[c])
                $display("FAIL tie cycle %0d: got %b want %b", c + 1, outs(), exp[c]);
            else
                passed++;
        end
    endtask

    task automatic test_store_we_hold();
        logic [6:0] exp [4];
        exp = '{7'b1010100, 7'b1010100, 7'b1010001, 7'b0000000};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            data_req = (c < 3);
            data_we  = (c < 2);
            step();
            total++;
            if (outs() !== exp[c])
                $display("FAIL store_we_hold cycle %0d: got %b want %b", c + 1, outs(), exp[c]);
            else
                passed++;
        end
    endtask

    task automatic test_mid_reset();
        logic [6:0] exp [7];
        exp = '{7'b1101000, 7'b1101000, 7'b0000000,
                7'b1101000, 7'b1101000, 7'b1100010, 7'b0000000};
        do_reset();
        for (int c = 0; c < 7; c++) begin
            rst_n   = (c != 2);
            ins_req = (c < 6);
            step();
            total++;
            if (outs() !== exp[c])
                $display("FAIL mid_reset cycle %0d: got %b want %b", c + 1, outs(), exp[c]);
            else
                passed++;
        end
        rst_n = 1'b1;
    endtask

    // Fetch held across two accesses, then a load whose request drops mid-access.
    task automatic test_back_to_back();
        logic [6:0] exp [12];
        exp = '{7'b1101000, 7'b1101000, 7'b1100010, 7'b0000000,
                7'b1101000, 7'b1101000, 7'b1100010, 7'b0000000,
                7'b1011000, 7'b1011000, 7'b1010001, 7'b0000000};
        do_reset();
        for (int c = 0; c < 12; c++) begin
            ins_req  = (c < 7);
            data_req = (c == 8);
            data_we  = 1'b0;
            step();
            total++;
            if (outs() !== exp[c])
                $display("FAIL back_to_back cycle %0d: got %b want %b", c + 1, outs(), exp[c]);
            else
                passed++;
        end
    endtask

    task automatic test_random();
        logic       was_idle, r_i, r_d;
        logic       last_w, exp_w, pend_w, pending;
        logic [1:0] sel_prev;
        logic       busy_prev;
        int         cyc, gcyc;
        do_reset();
        last_w    = 1'b1;
        pending   = 1'b0;
        pend_w    = 1'b0;
        sel_prev  = 2'b00;
        busy_prev = 1'b0;
        cyc       = 0;
        gcyc      = 0;
        for (int n = 0; n < 2000; n++) begin
            data_we  = 1'($urandom_range(0, 1));
            was_idle = !busy;
            r_i      = ins_req;
            r_d      = data_req;
            step();
            cyc++;

            total++;
            if (sel_ins && sel_data)
                $display("FAIL rnd_sel_onehot cycle %0d: got %b%b want not both", cyc, sel_ins, sel_data);
            else
                passed++;

            if (busy && busy_prev) begin
                total++;
                if ({sel_ins, sel_data} !== sel_prev)
                    $display("FAIL rnd_sel_stable cycle %0d: got %b want %b", cyc, {sel_ins, sel_data}, sel_prev);
                else
                    passed++;
            end

            if (pending && cyc == gcyc + LAT) begin
                total++;
                if ({ins_ack, data_ack} !== (pend_w ? 2'b01 : 2'b10))
                    $display("FAIL rnd_ack cycle %0d: got %b want %b", cyc, {ins_ack, data_ack},
                             pend_w ? 2'b01 : 2'b10);
                else
                    passed++;
                pending = 1'b0;
            end else if (ins_ack || data_ack) begin
                total++;
                $display("FAIL rnd_stray_ack cycle %0d: got %b want 00", cyc, {ins_ack, data_ack});
            end

            if (was_idle && (r_i || r_d)) begin
                exp_w = (r_i && r_d) ? !last_w : r_d;
                total++;
                if (busy !== 1'b1 || sel_data !== exp_w)
                    $display("FAIL rnd_grant cycle %0d: got busy=%b sel_data=%b want busy=1 sel_data=%b",
                             cyc, busy, sel_data, exp_w);
                else
                    passed++;
                last_w  = exp_w;
                pend_w  = exp_w;
                pending = 1'b1;
                gcyc    = cyc;
            end

            busy_prev = busy;
            sel_prev  = {sel_ins, sel_data};

            if (ins_ack)
                ins_req = 1'b0;
            else if (!ins_req && $urandom_range(0, 2) == 0)
                ins_req = 1'b1;
            if (data_ack)
                data_req = 1'b0;
            else if (!data_req && $urandom_range(0, 2) == 0)
                data_req = 1'b1;
        end
    endtask

    initial begin
        total    = 0;
        passed   = 0;
        rst_n    = 1'b0;
        ins_req  = 1'b0;
        data_req = 1'b0;
        data_we  = 1'b0;
        test_reset();
        test_ins_only();
        test_tie();
        test_store_we_hold();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
